// File: rtl/alu_cdb_tx.sv
// ALU execution stage: computes the result of each issued op and queues it in a small FIFO.
// The FIFO head is broadcast on the ALU CDB, one entry per grant.
module alu_cdb_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned OP_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [OP_W-1:0]   in_rs_op,
    input  logic [DATA_W-1:0] in_rs_value1,
    input  logic [DATA_W-1:0] in_rs_value2,
    input  logic [DATA_W-1:0] in_rs_imm,
    input  logic [TAG_W-1:0]  in_rs_rob_tag,
    input  logic [DATA_W-1:0] in_rs_pc,
    input  logic              in_flush,
    input  logic              in_cdb_grant,
    output logic              out_rs_stall,
    output logic              out_cdb_req,
    output logic [TAG_W-1:0]  out_cdb_tag,
    output logic [DATA_W-1:0] out_cdb_value,
    output logic              out_cdb_jump,
    output logic [DATA_W-1:0] out_cdb_target,
    output logic              out_overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Internal opcode encoding shared with the reservation station
    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

    logic [DATA_W-1:0] op2;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] res_value;
    logic              res_jump;
    logic [DATA_W-1:0] res_target;
    logic [DATA_W-1:0] pc_imm;

    always_comb begin
        op2        = (in_rs_op >= OP_ADDI && in_rs_op <= OP_SRAI) ? in_rs_imm : in_rs_value2;
        shamt      = op2[4:0];
        pc_imm     = in_rs_pc + in_rs_imm;
        res_value  = '0;
        res_jump   = 1'b0;
        res_target = '0;
        case (in_rs_op)
            OP_ADD, OP_ADDI:   res_value = in_rs_value1 + op2;
            OP_SUB:            res_value = in_rs_value1 - op2;
            OP_XOR, OP_XORI:   res_value = in_rs_value1 ^ op2;
            OP_OR, OP_ORI:     res_value = in_rs_value1 | op2;
            OP_AND, OP_ANDI:   res_value = in_rs_value1 & op2;
            OP_SLL, OP_SLLI:   res_value = in_rs_value1 << shamt;
            OP_SRL, OP_SRLI:   res_value = in_rs_value1 >> shamt;
            OP_SRA, OP_SRAI:   res_value = DATA_W'($signed(in_rs_value1) >>> shamt);
            OP_SLT, OP_SLTI:   res_value = DATA_W'($signed(in_rs_value1) < $signed(op2));
            OP_SLTU, OP_SLTIU: res_value = DATA_W'(in_rs_value1 < op2);
            OP_LUI:            res_value = in_rs_imm;
            OP_AUIPC:          res_value = pc_imm;
            OP_JAL: begin
                res_value  = in_rs_pc + DATA_W'(4);
                res_jump   = 1'b1;
                res_target = pc_imm;
            end
            OP_JALR: begin
                res_value  = in_rs_pc + DATA_W'(4);
                res_jump   = 1'b1;
                res_target = (in_rs_value1 + in_rs_imm) & ~DATA_W'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_target = pc_imm;
                case (in_rs_op)
                    OP_BEQ:  res_jump = (in_rs_value1 == in_rs_value2);
                    OP_BNE:  res_jump = (in_rs_value1 != in_rs_value2);
                    OP_BLT:  res_jump = ($signed(in_rs_value1) < $signed(in_rs_value2));
                    OP_BGE:  res_jump = ($signed(in_rs_value1) >= $signed(in_rs_value2));
                    OP_BLTU: res_jump = (in_rs_value1 < in_rs_value2);
                    default: res_jump = (in_rs_value1 >= in_rs_value2);
                endcase
            end
            default: ;
        endcase
    end

    logic [TAG_W-1:0]  tag_mem    [FIFO_DEPTH];
    logic [DATA_W-1:0] value_mem  [FIFO_DEPTH];
    logic              jump_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] target_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              full, do_push, do_pop, do_drop;

    always_comb begin
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        do_pop  = rdy && !in_flush && out_cdb_req && in_cdb_grant;
        // A full FIFO still accepts an issue when the head leaves on the same edge
        do_push = rdy && !in_flush && (in_rs_op != OP_NOP) && (!full || do_pop);
        do_drop = rdy && !in_flush && (in_rs_op != OP_NOP) && full && !do_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (rdy) begin
            if (in_flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
                else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
            end
            if (do_drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr_q]    <= in_rs_rob_tag;
            value_mem[wr_ptr_q]  <= res_value;
            jump_mem[wr_ptr_q]   <= res_jump;
            target_mem[wr_ptr_q] <= res_target;
        end
    end

    always_comb begin
        out_cdb_req    = (count_q != '0);
        out_cdb_tag    = out_cdb_req ? tag_mem[rd_ptr_q]    : '0;
        out_cdb_value  = out_cdb_req ? value_mem[rd_ptr_q]  : '0;
        out_cdb_jump   = out_cdb_req ? jump_mem[rd_ptr_q]   : 1'b0;
        out_cdb_target = out_cdb_req ? target_mem[rd_ptr_q] : '0;
        out_rs_stall   = (count_q >= CNT_W'(FIFO_DEPTH - 1));
        out_overflow   = overflow_q;
    end

endmodule

// File: tb/tb_alu_cdb_tx.sv
// Scoreboard bench for alu_cdb_tx: stimulus pushes expected broadcasts, a negedge monitor
// pops and compares each granted CDB transfer.
module tb_alu_cdb_tx;

    localparam logic [5:0] NOP = 6'd0, LUI = 6'd1, AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
    localparam logic [5:0] BEQ = 6'd5, BNE = 6'd6, BLT = 6'd7, BGE = 6'd8, BLTU = 6'd9;
    localparam logic [5:0] BGEU = 6'd10, ADDI = 6'd11, SLTIU = 6'd13, SRAI = 6'd19;
    localparam logic [5:0] ADD = 6'd20, SUB = 6'd21, SLT = 6'd23, SLTU = 6'd24, XOR = 6'd25;
    localparam logic [5:0] SRL = 6'd26, SRA = 6'd27;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [5:0]  in_rs_op = NOP;
    logic [31:0] in_rs_value1 = '0, in_rs_value2 = '0, in_rs_imm = '0, in_rs_pc = '0;
    logic [3:0]  in_rs_rob_tag = '0;
    logic        in_flush = 1'b0, in_cdb_grant = 1'b0;
    logic        out_rs_stall, out_cdb_req, out_cdb_jump, out_overflow;
    logic [3:0]  out_cdb_tag;
    logic [31:0] out_cdb_value, out_cdb_target;

    alu_cdb_tx #(.FIFO_DEPTH(4), .DATA_W(32), .TAG_W(4), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_rs_op(in_rs_op), .in_rs_value1(in_rs_value1), .in_rs_value2(in_rs_value2),
        .in_rs_imm(in_rs_imm), .in_rs_rob_tag(in_rs_rob_tag), .in_rs_pc(in_rs_pc),
        .in_flush(in_flush), .in_cdb_grant(in_cdb_grant),
        .out_rs_stall(out_rs_stall), .out_cdb_req(out_cdb_req), .out_cdb_tag(out_cdb_tag),
        .out_cdb_value(out_cdb_value), .out_cdb_jump(out_cdb_jump),
        .out_cdb_target(out_cdb_target), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: a transfer happens on the coming edge when the head is granted
    always @(negedge clk) begin
        if (rst && rdy && !in_flush && out_cdb_req && in_cdb_grant) begin
            exp_t got;
            got = '{tag: out_cdb_tag, value: out_cdb_value, jump: out_cdb_jump,
                    target: out_cdb_target};
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_broadcast: got tag %0h, want none", out_cdb_tag);
            end else begin
                check($sformatf("cdb_tag%0d", sb[0].tag), 72'(got), 72'(sb[0]));
                void'(sb.pop_front());
            end
        end
    end

    // Drive one op for one edge; `accept` says whether the scoreboard should expect it
    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                         input bit accept, input logic [31:0] e_val, input logic e_jump,
                         input logic [31:0] e_tgt);
        in_rs_op = op; in_rs_value1 = v1; in_rs_value2 = v2;
        in_rs_imm = imm; in_rs_pc = pc; in_rs_rob_tag = tag;
        if (accept) sb.push_back('{tag: tag, value: e_val, jump: e_jump, target: e_tgt});
        @(posedge clk); #1;
        in_rs_op = NOP;
    endtask

    task automatic drain(input string name);
        bit done = 0;
        in_cdb_grant = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (!out_cdb_req) done = 1;
        end
        check(name, 72'(out_cdb_req), 72'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_cdb_req, out_cdb_tag, out_cdb_value, out_cdb_jump,
              out_cdb_target, out_rs_stall, out_overflow}, 72'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Single ADD, granted as soon as visible
        in_cdb_grant = 1'b1;
        issue(ADD, 5, 7, 0, 0, 4'd3, 1, 32'd12, 0, 0);
        check("add_visible", {out_cdb_req, out_cdb_tag}, {1'b1, 4'd3});
        @(posedge clk); #1;
        check("add_empty_after_grant", 72'(out_cdb_req), 72'(0));

        // Fill, stall, overflow, then strict-order drain
        in_cdb_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(ADDI, 32'(i * 10), 0, 1, 0, 4'(i), 1, 32'(i * 10 + 1), 0, 0);
            if (i == 2) check("stall_at_2", 72'(out_rs_stall), 72'(0));
            if (i == 3) check("stall_at_3", 72'(out_rs_stall), 72'(1));
        end
        check("no_overflow_at_full", 72'(out_overflow), 72'(0));
        issue(ADDI, 32'd50, 0, 1, 0, 4'd5, 0, 0, 0, 0);
        check("overflow_set", 72'(out_overflow), 72'(1));
        drain("drain_full");

        // Directed ALU/branch/jump vectors, each popped on the following edge
        issue(BLT,   32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4'd6, 1, 0, 1, 32'h120);
        issue(BLTU,  32'hFFFF_FFFF, 1, 32'h20, 32'h100, 4'd7, 1, 0, 0, 32'h120);
        issue(JALR,  32'h1003, 0, 4, 32'h40, 4'd8, 1, 32'h44, 1, 32'h1006);
        issue(SUB,   3, 5, 0, 0, 4'd9, 1, 32'hFFFF_FFFE, 0, 0);
        issue(SRA,   32'h8000_0000, 4, 0, 0, 4'd10, 1, 32'hF800_0000, 0, 0);
        issue(SRAI,  32'h8000_0010, 0, 32'h404, 0, 4'd11, 1, 32'hF800_0001, 0, 0);
        issue(SRL,   32'h8000_0000, 32'h21, 0, 0, 4'd12, 1, 32'h4000_0000, 0, 0);
        issue(SLT,   32'hFFFF_FFFF, 1, 0, 0, 4'd13, 1, 1, 0, 0);
        issue(SLTU,  32'hFFFF_FFFF, 1, 0, 0, 4'd14, 1, 0, 0, 0);
        issue(SLTIU, 1, 0, 32'hFFFF_FFFF, 0, 4'd15, 1, 1, 0, 0);
        issue(LUI,   0, 0, 32'h1234_5000, 0, 4'd1, 1, 32'h1234_5000, 0, 0);
        issue(AUIPC, 0, 0, 32'h2000, 32'h1000, 4'd2, 1, 32'h3000, 0, 0);
        issue(JAL,   0, 0, 32'hFFFF_FFF0, 32'h200, 4'd3, 1, 32'h204, 1, 32'h1F0);
        issue(BEQ,   5, 5, 8, 32'h10, 4'd4, 1, 0, 1, 32'h18);
        issue(BNE,   5, 5, 8, 32'h10, 4'd5, 1, 0, 0, 32'h18);
        issue(BGE,   32'hFFFF_FFFF, 1, 8, 32'h10, 4'd6, 1, 0, 0, 32'h18);
        issue(BGEU,  32'hFFFF_FFFF, 1, 8, 32'h10, 4'd7, 1, 0, 1, 32'h18);
        issue(6'd63, 9, 9, 9, 9, 4'd8, 1, 0, 0, 0);
        drain("drain_vectors");

        // Flush with concurrent issue and grant
        in_cdb_grant = 1'b0;
        for (int i = 1; i <= 3; i++) issue(ADD, 32'(i), 1, 0, 0, 4'(i), 1, 32'(i + 1), 0, 0);
        in_flush = 1'b1; in_cdb_grant = 1'b1;
        issue(ADD, 1, 1, 0, 0, 4'd9, 0, 0, 0, 0);
        in_flush = 1'b0; in_cdb_grant = 1'b0;
        sb.delete();
        check("flush_empty", {out_cdb_req, out_cdb_tag, out_rs_stall}, 72'(0));
        check("flush_keeps_overflow", 72'(out_overflow), 72'(1));

        // rdy low freezes queue despite grant and issue
        issue(XOR, 32'hF0, 32'h0F, 0, 0, 4'd10, 1, 32'hFF, 0, 0);
        issue(XOR, 32'hAA, 32'hFF, 0, 0, 4'd11, 1, 32'h55, 0, 0);
        rdy = 1'b0; in_cdb_grant = 1'b1;
        in_rs_op = ADD; in_rs_rob_tag = 4'd12;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rdy_hold_%0d", i), {out_cdb_req, out_cdb_tag, out_cdb_value},
                  {1'b1, 4'd10, 32'hFF});
        end
        in_rs_op = NOP; rdy = 1'b1;
        drain("drain_after_rdy");

        // Async reset mid-queue
        in_cdb_grant = 1'b0;
        issue(ADD, 1, 2, 0, 0, 4'd13, 1, 3, 0, 0);
        issue(JAL, 0, 0, 8, 32'h10, 4'd14, 1, 32'h14, 1, 32'h18);
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs", {out_cdb_req, out_cdb_tag, out_cdb_value, out_cdb_jump,
              out_cdb_target, out_rs_stall, out_overflow}, 72'(0));
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1; in_cdb_grant = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_bcast_after_reset", 72'(out_cdb_req), 72'(0));
        check("scoreboard_empty", 72'(sb.size()), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
